// File: rtl/add_share_arbiter_pkg.sv
// Shared types and helpers for the add_share_arbiter block: FSM states,
// adder width and the registered response record.
package add_share_arbiter_pkg;

  localparam int ADD_W   = 8;
  localparam int MAX_IDW = 3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // id is sized for the largest supported requester count; the top truncates it
  typedef struct packed {
    logic [ADD_W-1:0]   sum;
    logic               cout;
    logic [MAX_IDW-1:0] id;
    logic               eop;
  } rsp_t;

  function automatic logic [ADD_W:0] add_with_carry(
    input logic [ADD_W-1:0] a,
    input logic [ADD_W-1:0] b,
    input logic             cin
  );
    return {1'b0, a} + {1'b0, b} + {{ADD_W{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/add_share_arbiter_rr_arbiter.sv
// Round-robin picker: one-hot grant to the first active request found
// searching upward from ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_share_arbiter.sv
// Shares one registered 8-bit add stage among NREQ requesters; multi-beat
// packets hold the grant and chain the carry so wide adds run byte-serially.
module add_share_arbiter
  import add_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [ADD_W*NREQ-1:0] req_a,
  input  logic [ADD_W*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_sop,
  input  logic [NREQ-1:0]       req_eop,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADD_W-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_eop,
  output logic                  err
);

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   owner;
  logic [IDW-1:0]   acc_id;
  logic [IDW-1:0]   next_ptr;
  logic [NREQ-1:0]  arb_grant;
  logic [NREQ-1:0]  grant;
  logic             out_free;
  logic             accept;
  logic             carry;
  logic [ADD_W-1:0] sel_a;
  logic [ADD_W-1:0] sel_b;
  logic             sel_cin;
  logic             sel_sop;
  logic             sel_eop;
  logic             add_cin;
  logic             proto_err;
  logic [ADD_W:0]   add_res;
  logic             rsp_valid_q;
  rsp_t             rsp_q;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(arb_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept && !sel_eop) state_nxt = ST_LOCKED;
      ST_LOCKED: if (accept && sel_eop)  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // While locked only the packet owner may proceed, valid or not
  always_comb begin
    grant = '0;
    case (state)
      ST_IDLE:   grant = arb_grant;
      ST_LOCKED: grant[owner] = 1'b1;
      default:   grant = '0;
    endcase
    out_free  = ~rsp_valid_q | rsp_ready;
    req_ready = grant & {NREQ{out_free}};
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    sel_sop = 1'b0;
    sel_eop = 1'b0;
    acc_id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a   = req_a[ADD_W*i +: ADD_W];
        sel_b   = req_b[ADD_W*i +: ADD_W];
        sel_cin = req_cin[i];
        sel_sop = req_sop[i];
        sel_eop = req_eop[i];
        acc_id  = IDW'(i);
      end
    end
  end

  // A beat arriving in IDLE always starts a packet, so it takes its own cin
  assign accept    = |(req_valid & req_ready);
  assign add_cin   = (state == ST_IDLE || sel_sop) ? sel_cin : carry;
  assign proto_err = accept && ((state == ST_IDLE) ? !sel_sop : sel_sop);
  assign add_res   = add_with_carry(sel_a, sel_b, add_cin);
  assign next_ptr  = (acc_id == IDW'(NREQ-1)) ? '0 : acc_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      owner <= '0;
      carry <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        carry <= add_res[ADD_W];
        if (sel_eop)                ptr   <= next_ptr;
        else if (state == ST_IDLE)  owner <= acc_id;
      end
      if (proto_err) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_q.sum   <= add_res[ADD_W-1:0];
      rsp_q.cout  <= add_res[ADD_W];
      rsp_q.id    <= MAX_IDW'(acc_id);
      rsp_q.eop   <= sel_eop;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_id    = IDW'(rsp_q.id);
  assign rsp_eop   = rsp_q.eop;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed and randomized checks of add_share_arbiter against a
// transaction-level model of arbitration, carry chaining and error flags.
module tb_add_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_sop;
  logic [NREQ-1:0]   req_eop;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_sum;
  logic              rsp_cout;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_eop;
  logic              err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_locked;
  int m_owner, m_ptr;
  bit m_carry, m_err, m_rsp_valid;
  int m_sum, m_cout, m_id, m_eop;

  add_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .req_sop(req_sop), .req_eop(req_eop),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
    .rsp_eop(rsp_eop), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input bit v, input logic [7:0] a, input logic [7:0] b,
                               input bit cin, input bit sop, input bit eop);
    req_valid[i]    = v;
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_cin[i]      = cin;
    req_sop[i]      = sop;
    req_eop[i]      = eop;
  endtask

  task automatic clearInputs();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 0, 8'h00, 8'h00, 0, 0, 0);
  endtask

  function automatic logic [NREQ-1:0] modelReady();
    logic [NREQ-1:0] r;
    int idx;
    r = '0;
    if (m_rsp_valid && !rsp_ready) return r;
    if (m_locked) begin
      r[m_owner] = 1'b1;
      return r;
    end
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) begin
        r[idx] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // One clock: check handshake, advance the model, check registered outputs
  task automatic stepCycle();
    logic [NREQ-1:0] exp_ready, acc;
    bit c_rst, c_rsp_ready;
    int k, total, cin_used;
    #1;
    exp_ready = modelReady();
    if (!rst) checkOutput("req_ready", req_ready, exp_ready);
    acc = exp_ready & req_valid;
    c_rst = rst;
    c_rsp_ready = rsp_ready;
    k = -1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) k = i;
    if (c_rst) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_carry = 0; m_err = 0;
      m_rsp_valid = 0; m_sum = 0; m_cout = 0; m_id = 0; m_eop = 0;
    end else if (k >= 0) begin
      cin_used = (!m_locked || req_sop[k]) ? int'(req_cin[k]) : int'(m_carry);
      total = int'(req_a[8*k +: 8]) + int'(req_b[8*k +: 8]) + cin_used;
      if (m_locked == req_sop[k]) m_err = 1;
      m_carry = (total >= 256);
      m_sum = total % 256;
      m_cout = total / 256;
      m_id = k;
      m_eop = req_eop[k];
      m_rsp_valid = 1;
      if (req_eop[k]) begin
        m_locked = 0;
        m_ptr = (k + 1) % NREQ;
      end else if (!m_locked) begin
        m_locked = 1;
        m_owner = k;
      end
    end else if (c_rsp_ready) begin
      m_rsp_valid = 0;
    end
    @(posedge clk);
    #1;
    checkOutput("rsp_valid", rsp_valid, m_rsp_valid);
    checkOutput("err", err, m_err);
    if (m_rsp_valid) begin
      checkOutput("rsp_sum", rsp_sum, m_sum);
      checkOutput("rsp_cout", rsp_cout, m_cout);
      checkOutput("rsp_id", rsp_id, m_id);
      checkOutput("rsp_eop", rsp_eop, m_eop);
    end
  endtask

  initial begin
    logic [7:0] held_sum;
    int fair_ids [5] = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    rsp_ready = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    stepCycle();
    checkOutput("reset_valid", rsp_valid, 0);
    checkOutput("reset_sum", rsp_sum, 0);
    checkOutput("reset_cout", rsp_cout, 0);
    checkOutput("reset_id", rsp_id, 0);
    checkOutput("reset_eop", rsp_eop, 0);
    checkOutput("reset_err", err, 0);
    rst = 1'b0;

    $display("[TB] fairness");
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1, 8'(i), 8'h01, 0, 1, 1);
    for (int n = 0; n < 5; n++) begin
      stepCycle();
      checkOutput("fair_id", rsp_id, fair_ids[n]);
    end
    clearInputs();
    stepCycle();

    $display("[TB] single beat");
    applyStimulus(0, 1, 8'h3C, 8'h05, 1, 1, 1);
    stepCycle();
    checkOutput("single_sum", rsp_sum, 8'h42);
    checkOutput("single_cout", rsp_cout, 0);
    checkOutput("single_id", rsp_id, 0);
    checkOutput("single_eop", rsp_eop, 1);
    clearInputs();
    stepCycle();

    $display("[TB] 16-bit chain");
    applyStimulus(0, 1, 8'h11, 8'h22, 0, 1, 1);
    applyStimulus(2, 1, 8'hFF, 8'h01, 0, 1, 0);
    stepCycle();
    checkOutput("chain0_sum", rsp_sum, 8'h00);
    checkOutput("chain0_cout", rsp_cout, 1);
    applyStimulus(2, 1, 8'h00, 8'h00, 0, 0, 1);
    #1;
    checkOutput("chain_lock_ready", req_ready, 4'b0100);
    stepCycle();
    checkOutput("chain1_sum", rsp_sum, 8'h01);
    checkOutput("chain1_cout", rsp_cout, 0);
    clearInputs();
    stepCycle();

    $display("[TB] backpressure");
    applyStimulus(0, 1, 8'h01, 8'h02, 0, 1, 1);
    stepCycle();
    held_sum = rsp_sum;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0);
    applyStimulus(1, 1, 8'h20, 8'h22, 0, 1, 1);
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checkOutput("bp_ready", req_ready, 4'b0000);
      stepCycle();
      checkOutput("bp_hold_sum", rsp_sum, held_sum);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", req_ready, 4'b0010);
    stepCycle();
    checkOutput("bp_release_sum", rsp_sum, 8'h42);
    clearInputs();
    stepCycle();

    $display("[TB] protocol error");
    applyStimulus(3, 1, 8'h10, 8'h10, 1, 0, 1);
    stepCycle();
    checkOutput("perr_sum", rsp_sum, 8'h21);
    checkOutput("perr_err", err, 1);
    clearInputs();
    repeat (3) stepCycle();
    checkOutput("perr_sticky", err, 1);

    $display("[TB] reset mid-packet");
    applyStimulus(2, 1, 8'hF0, 8'h20, 0, 1, 0);
    stepCycle();
    clearInputs();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("mid_rst_valid", rsp_valid, 0);
    checkOutput("mid_rst_err", err, 0);
    applyStimulus(1, 1, 8'h01, 8'h01, 1, 1, 1);
    #1;
    checkOutput("mid_rst_ready", req_ready, 4'b0010);
    stepCycle();
    checkOutput("mid_rst_sum", rsp_sum, 8'h03);
    clearInputs();
    stepCycle();

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++)
        applyStimulus(i, $urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom),
                      1'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
      rsp_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 63) == 0;
      stepCycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_share_arbiter.md
# add_share_arbiter

Round-robin arbiter and sequencer that shares one registered 8-bit add stage among `NREQ` requesters. Each requester submits 8-bit operand beats over a valid/ready handshake, and the result returns on a single response port tagged with the requester ID. Multi-byte packets keep the grant and chain the carry from beat to beat, so wide additions run byte-serially on the shared stage. The block sits between the operand-producing engines and the 8-bit conditional-sum adder datapath.

## Interface
- `NREQ`, 4 — number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)` — width of the requester ID.

- `clk`  in  1  — clock.
- `rst`  in  1  — reset, synchronous, active-high.
- `req_valid`  in  `NREQ`  — per-requester beat valid.
- `req_ready`  out  `NREQ`  — per-requester beat accepted this cycle.
- `req_a`  in  `8*NREQ`  — operand A; requester i uses `[8i+7:8i]`.
- `req_b`  in  `8*NREQ`  — operand B, same packing.
- `req_cin`  in  `NREQ`  — carry-in; used only on SOP beats.
- `req_sop`  in  `NREQ`  — first beat of a packet.
- `req_eop`  in  `NREQ`  — last beat of a packet.
- `rsp_valid`  out  1  — result valid.
- `rsp_ready`  in  1  — downstream accepts the result.
- `rsp_sum`  out  8  — sum byte.
- `rsp_cout`  out  1  — carry-out of this beat.
- `rsp_id`  out  `IDW`  — requester that produced the beat.
- `rsp_eop`  out  1  — copy of `req_eop` for this beat.
- `err`  out  1  — sticky protocol error.

## Operation
- Beat accepted on requester i when `req_valid[i] & req_ready[i]`.
- `req_ready[i] = grant[i] & (~rsp_valid | rsp_ready)`. At most one bit of `req_ready` is high.
- Two-state FSM:
  - IDLE: the grant goes to the first valid requester, searching upward from `ptr` modulo `NREQ`.
    - Accepted beat with eop=1 → stay IDLE, `ptr <= i+1` (mod `NREQ`).
    - Accepted beat with eop=0 → go to LOCKED, `owner <= i`.
  - LOCKED: the grant goes only to `owner`; all other requesters see `ready=0`.
    - Accepted eop beat → IDLE, `ptr <= owner+1` (mod `NREQ`).
- Carry-in for the add:
  - SOP beat: `req_cin[i]`.
  - Non-SOP beat: the stored `carry` register.
  - `carry <= cout` on every accepted beat.
- Add: `{cout,sum} = a + b + cin`, 9-bit result. This is a plain binary add; the internal structure is free.
- Output register: loaded on accept with `sum`, `cout`, `id`, `eop`; `rsp_valid <= 1`. Cleared when `rsp_ready` is high and no new beat is accepted.
- Simultaneous `rsp_ready` and a new accept → the register reloads and `rsp_valid` stays 1. This gives full throughput of one beat per cycle.
- Protocol errors:
  - In IDLE, an accepted beat with sop=0 is treated as SOP (uses `req_cin`) and sets `err`.
  - In LOCKED, an owner beat with sop=1 uses `req_cin`, keeps the lock, and sets `err`.
  - `err` clears only on `rst`.
- Reset:
  - Outputs: `rsp_valid=0`, `rsp_sum=0`, `rsp_cout=0`, `rsp_id=0`, `rsp_eop=0`, `err=0`.
  - Internal: state IDLE, `ptr=0`, `owner=0`, `carry=0`.
  - Reset mid-packet drops the lock and any pending result with no response.

## Timing
- Latency: beat accepted in cycle N → `rsp_valid` with its result in cycle N+1.
- `req_ready` is combinational from `req_valid`, the FSM state, `rsp_valid` and `rsp_ready`. No combinational path from `req_a`/`req_b` to any output.
- Backpressure: while `rsp_valid & ~rsp_ready`, all `req_ready` are 0 and the output register holds.
- The grant may change any cycle in IDLE. A requester that drops `req_valid` before acceptance loses nothing.
- A requester with valid held in IDLE is granted within `NREQ` packet completions.

## Structure
- Shared package:
  - state enum (`ST_IDLE`, `ST_LOCKED`);
  - the `ADD_W=8` constant;
  - a response struct {sum, cout, id, eop}.
- One sub-module: `rr_arbiter` (parameter `NREQ`; inputs `req`, `ptr`; output one-hot `grant`).
- FSM, carry register, add and output register live in the top level.

## Test plan
- Single beat: req0 a=0x3C b=0x05 cin=1, sop=eop=1 → next cycle `rsp_sum=0x42`, `rsp_cout=0`, `rsp_id=0`, `rsp_eop=1`.
- 16-bit chain: req2 beats (0xFF+0x01, cin=0, sop) then (0x00+0x00, eop) → sums 0x00/cout=1, then 0x01/cout=0. Other requesters see ready=0 between the two beats.
- Fairness: all 4 requesters valid with single beats, no backpressure → `rsp_id` sequence 0,1,2,3,0 in consecutive cycles.
- Backpressure: `rsp_ready=0` for 3 cycles with req1 valid → all `req_ready=0` and `rsp_sum` stable. Then `rsp_ready=1` → req1 accepted the same cycle, its result the next cycle.
- Protocol error: in IDLE, req3 sends sop=0 a=0x10 b=0x10 cin=1 → `rsp_sum=0x21` and `err=1`, persisting until `rst`.
- Reset mid-packet: `rst` after the first beat of a 2-beat packet → state IDLE and `rsp_valid=0`. A new req1 single beat is granted at once, using its own cin.
